// File: rtl/matrix_pkg.sv
// Constants and state types shared by the matrix receive and transmit paths.
package matrix_pkg;
    localparam int MAX_DIM   = 5;
    localparam int ELEM_W    = 8;
    localparam int MAX_ELEMS = 25;
    localparam int MATRIX_W  = 200;

    typedef enum logic [1:0] {WAIT_M, WAIT_N, ELEMS} parse_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic dim_ok(input logic [7:0] b);
        return (b >= 8'd1) && (b <= 8'(MAX_DIM));
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
module uart_rx_byte
    import matrix_pkg::*;
#(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       uartRxRst,
    input  logic       rx,
    output logic [7:0] byteData,
    output logic       byteValid,
    output logic       byteErr
);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    rx_state_t     state, state_n;
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          fall;

    assign fall     = rx_prev & ~rx_s;
    assign byteData = shreg;

    always_ff @(posedge clk or posedge uartRxRst) begin
        if (uartRxRst) state <= RX_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RX_IDLE:  if (fall) state_n = RX_START;
            RX_START: if (cnt == CW'(HALF - 1)) state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == CW'(CPB - 1) && bit_idx == 3'd7) state_n = RX_STOP;
            RX_STOP:  if (cnt == CW'(CPB - 1)) state_n = RX_IDLE;
            default:  state_n = RX_IDLE;
        endcase
    end

    // Line idles high, so the synchroniser and edge history reset to 1.
    always_ff @(posedge clk or posedge uartRxRst) begin
        if (uartRxRst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byteValid <= 1'b0;
            byteErr   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            byteValid <= 1'b0;
            byteErr   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= (cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
                RX_DATA: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CPB - 1)) begin
                        byteValid <= rx_s;
                        byteErr   <= ~rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: rtl/matrix_uart_rx.sv
// Receives m, n and m*n row-major element bytes over UART and publishes the matrix.
module matrix_uart_rx
    import matrix_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                clk,
    input  logic                uartRxRst,
    input  logic                uartRx,
    output logic [MATRIX_W-1:0] matrixData,
    output logic [7:0]          m,
    output logic [7:0]          n,
    output logic                matrixValid,
    output logic                frameErr,
    output logic                busy
);
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [7:0]          byte_data;
    logic                byte_valid, byte_err;
    parse_state_t        state, state_n;
    logic [2:0]          m_tmp, n_tmp;
    logic [4:0]          total, idx;
    logic [MATRIX_W-1:0] shadow, shadow_nxt;
    logic [TW-1:0]       tcnt;
    logic                timeout, dim_valid;
    logic                accept_m, accept_n, take_elem, done, abort;

    uart_rx_byte #(.CPB(CPB)) u_rx (
        .clk       (clk),
        .uartRxRst (uartRxRst),
        .rx        (uartRx),
        .byteData  (byte_data),
        .byteValid (byte_valid),
        .byteErr   (byte_err)
    );

    assign busy      = (state != WAIT_M);
    assign dim_valid = dim_ok(byte_data);
    assign timeout   = busy && !byte_valid && (tcnt == TW'(TO_LIMIT - 1));

    // Shadow with the current byte merged in, so the last element lands in the same edge as publish.
    always_comb begin
        shadow_nxt = shadow;
        if (idx < 5'(MAX_ELEMS)) shadow_nxt[{idx, 3'b000} +: ELEM_W] = byte_data;
    end

    always_ff @(posedge clk or posedge uartRxRst) begin
        if (uartRxRst) state <= WAIT_M;
        else           state <= state_n;
    end

    always_comb begin
        state_n   = state;
        abort     = 1'b0;
        done      = 1'b0;
        accept_m  = 1'b0;
        accept_n  = 1'b0;
        take_elem = 1'b0;
        if (byte_err || timeout) begin
            state_n = WAIT_M;
            abort   = 1'b1;
        end else if (byte_valid) begin
            case (state)
                WAIT_M: begin
                    if (dim_valid) begin
                        state_n  = WAIT_N;
                        accept_m = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
                WAIT_N: begin
                    state_n = dim_valid ? ELEMS : WAIT_M;
                    accept_n = dim_valid;
                    abort    = !dim_valid;
                end
                ELEMS: begin
                    take_elem = 1'b1;
                    if (idx == total - 5'd1) begin
                        done    = 1'b1;
                        state_n = WAIT_M;
                    end
                end
                default: state_n = WAIT_M;
            endcase
        end
    end

    always_ff @(posedge clk or posedge uartRxRst) begin
        if (uartRxRst) begin
            matrixData  <= '0;
            m           <= '0;
            n           <= '0;
            matrixValid <= 1'b0;
            frameErr    <= 1'b0;
            m_tmp       <= '0;
            n_tmp       <= '0;
            total       <= '0;
            idx         <= '0;
            shadow      <= '0;
            tcnt        <= '0;
        end else begin
            matrixValid <= done;
            frameErr    <= abort;
            tcnt        <= (busy && !byte_valid) ? tcnt + 1'b1 : '0;
            if (accept_m) m_tmp <= byte_data[2:0];
            if (accept_n) begin
                n_tmp  <= byte_data[2:0];
                total  <= {2'b00, m_tmp} * {2'b00, byte_data[2:0]};
                shadow <= '0;
                idx    <= '0;
            end
            if (take_elem) begin
                shadow <= shadow_nxt;
                idx    <= idx + 5'd1;
            end
            if (done) begin
                matrixData <= shadow_nxt;
                m          <= {5'b00000, m_tmp};
                n          <= {5'b00000, n_tmp};
            end
        end
    end
endmodule

// File: tb/tb_matrix_uart_rx.sv
// Directed bench for matrix_uart_rx: serial frames in, scoreboard of expected matrices out.
module tb_matrix_uart_rx;
    localparam int CPB = 16;

    logic         clk;
    logic         uartRxRst;
    logic         uartRx;
    logic [199:0] matrixData;
    logic [7:0]   m, n;
    logic         matrixValid, frameErr, busy;

    matrix_uart_rx #(.CLK_FREQ(160), .BAUD(10), .TIMEOUT_BITS(64)) dut (
        .clk         (clk),
        .uartRxRst   (uartRxRst),
        .uartRx      (uartRx),
        .matrixData  (matrixData),
        .m           (m),
        .n           (n),
        .matrixValid (matrixValid),
        .frameErr    (frameErr),
        .busy        (busy)
    );

    // Scoreboard: {m, n, matrixData} per expected frame, plus the cycle it must appear.
    logic [215:0] exp_q[$];
    int           exp_cyc_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_mv = 0;
    int n_ferr = 0;
    int last_ferr_cyc = -1;

    logic [215:0] e;
    int           ec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!uartRxRst) begin
                if (matrixValid || frameErr)
                    check("valid_err_exclusive", 256'(matrixValid & frameErr), 256'(0));
                if (frameErr) begin
                    n_ferr++;
                    last_ferr_cyc = cyc;
                end
                if (matrixValid) begin
                    n_mv++;
                    check("valid_expected", 256'(exp_q.size() != 0), 256'(1));
                    if (exp_q.size() != 0) begin
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        check("valid_cycle", 256'(cyc), 256'(ec));
                        check("frame_m", 256'(m), 256'(e[215:208]));
                        check("frame_n", 256'(n), 256'(e[207:200]));
                        check("frame_data", 256'(matrixData), 256'(e[199:0]));
                    end
                end
            end
        end
    end

    // Callers start aligned at 1 time unit after a rising edge; returns aligned the same way.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        logic [9:0] bits;
        bits = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uartRx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uartRx = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Stop bit of the last byte is sampled 155 edges after its start; matrixValid follows one clk later.
    task automatic send_frame(input logic [7:0] mm, input logic [7:0] nn, input logic [199:0] d);
        int cnt;
        cnt = int'(mm) * int'(nn);
        exp_q.push_back({mm, nn, d});
        send_byte(mm);
        send_byte(nn);
        for (int k = 0; k < cnt; k++) begin
            if (k == cnt - 1) exp_cyc_q.push_back(cyc + 156);
            send_byte(d[8*k +: 8]);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        summary();
        $finish;
    end

    initial begin
        logic [199:0] d;
        int mv0, fe0, s;

        uartRx    = 1'b1;
        uartRxRst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 256'(matrixData), 256'(0));
        check("rst_m", 256'(m), 256'(0));
        check("rst_n", 256'(n), 256'(0));
        check("rst_valid", 256'(matrixValid), 256'(0));
        check("rst_ferr", 256'(frameErr), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        uartRxRst = 1'b0;
        idle(5);

        // 2x3 frame, bytes back-to-back
        mv0 = n_mv;
        fe0 = n_ferr;
        exp_q.push_back({8'd2, 8'd3, 200'h060504030201});
        send_byte(8'd2);
        check("busy_after_m", 256'(busy), 256'(1));
        send_byte(8'd3);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) exp_cyc_q.push_back(cyc + 156);
            send_byte(8'(k));
        end
        idle(10);
        check("f23_pulses", 256'(n_mv - mv0), 256'(1));
        check("f23_busy", 256'(busy), 256'(0));
        check("f23_no_ferr", 256'(n_ferr - fe0), 256'(0));

        // 5x5 frame 0x01..0x19, then 1x1
        d = '0;
        for (int k = 0; k < 25; k++) d[8*k +: 8] = 8'(k + 1);
        mv0 = n_mv;
        send_frame(8'd5, 8'd5, d);
        send_frame(8'd1, 8'd1, 200'hAA);
        idle(10);
        check("f55_f11_pulses", 256'(n_mv - mv0), 256'(2));

        // invalid m, then a valid 1x1
        fe0 = n_ferr;
        mv0 = n_mv;
        s = cyc;
        send_byte(8'd6);
        idle(4);
        check("bad_m_ferr", 256'(n_ferr - fe0), 256'(1));
        check("bad_m_ferr_cyc", 256'(last_ferr_cyc), 256'(s + 156));
        check("bad_m_busy", 256'(busy), 256'(0));
        send_frame(8'd1, 8'd1, 200'h07);
        idle(10);
        check("after_bad_m_pulses", 256'(n_mv - mv0), 256'(1));

        // stop-bit error on the 3rd element of a 2x2
        fe0 = n_ferr;
        mv0 = n_mv;
        send_byte(8'd2);
        send_byte(8'd2);
        send_byte(8'd9);
        send_byte(8'd9);
        s = cyc;
        send_byte(8'h33, 1'b1);
        idle(20);
        check("stop_err_ferr", 256'(n_ferr - fe0), 256'(1));
        check("stop_err_ferr_cyc", 256'(last_ferr_cyc), 256'(s + 156));
        check("stop_err_no_valid", 256'(n_mv - mv0), 256'(0));
        check("stop_err_busy", 256'(busy), 256'(0));
        check("hold_m", 256'(m), 256'(1));
        check("hold_n", 256'(n), 256'(1));
        check("hold_data", 256'(matrixData), 256'(7));

        // 4-clock low glitch on the idle line
        fe0 = n_ferr;
        mv0 = n_mv;
        uartRx = 1'b0;
        idle(4);
        uartRx = 1'b1;
        idle(200);
        check("glitch_no_ferr", 256'(n_ferr - fe0), 256'(0));
        check("glitch_busy", 256'(busy), 256'(0));
        send_frame(8'd1, 8'd1, 200'h55);
        idle(10);
        check("after_glitch_pulses", 256'(n_mv - mv0), 256'(1));

        // timeout: 1024 clocks after the point a completing element would publish
        fe0 = n_ferr;
        mv0 = n_mv;
        send_byte(8'd2);
        send_byte(8'd2);
        s = cyc;
        send_byte(8'd1);
        idle(900);
        check("to_busy_before", 256'(busy), 256'(1));
        idle(400);
        check("to_ferr", 256'(n_ferr - fe0), 256'(1));
        check("to_ferr_cyc", 256'(last_ferr_cyc), 256'(s + 1180));
        check("to_busy", 256'(busy), 256'(0));
        check("to_no_valid", 256'(n_mv - mv0), 256'(0));
        check("to_hold_data", 256'(matrixData), 256'(8'h55));

        // reset mid-byte of a partial frame
        send_byte(8'd3);
        uartRx = 1'b0;
        idle(40);
        #2;
        uartRxRst = 1'b1;
        #1;
        check("mrst_data", 256'(matrixData), 256'(0));
        check("mrst_m", 256'(m), 256'(0));
        check("mrst_n", 256'(n), 256'(0));
        check("mrst_busy", 256'(busy), 256'(0));
        check("mrst_valid", 256'(matrixValid), 256'(0));
        check("mrst_ferr", 256'(frameErr), 256'(0));
        uartRx = 1'b1;
        idle(5);
        uartRxRst = 1'b0;
        idle(5);
        mv0 = n_mv;
        send_frame(8'd1, 8'd1, 200'h3C);
        idle(10);
        check("after_rst_pulses", 256'(n_mv - mv0), 256'(1));
        check("queue_drained", 256'(exp_q.size()), 256'(0));

        summary();
        $finish;
    end
endmodule
